spmm_hls_sdiv_16s_16s_16_seq: RTL and testbench
===============================================

Name: spmm_hls_sdiv_16s_16s_16_seq

Overview:
Sequential signed integer divider. It is the inverse-direction companion of the pipelined spmm_hls_mul 16s×16s DSP multiplier, used for row normalisation and scaling in the SpMM datapath. It accepts a dividend/divisor pair over a valid/ready handshake and runs a radix-2 restoring division with constant latency. It returns the quotient and remainder with C semantics (truncate toward zero), plus divide-by-zero and overflow flags.

Parameters:
W, 16, operand/quotient/remainder width in bits (two's complement); must be ≥ 2
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > W

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
ce  in  1  clock enable; 0 freezes all registers, including the handshake state
in_valid  in  1  operand pair valid
in_ready  out  1  divider can accept operands
din0  in  W  signed dividend
din1  in  W  signed divisor
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
quot  out  W  signed quotient
rem  out  W  signed remainder; sign follows dividend
div_by_zero  out  1  flag: din1 was 0
overflow  out  1  flag: din0 = -2^(W-1) and din1 = -1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; in_ready=1 once reset releases. out_valid, quot, rem, div_by_zero, overflow, counter and internal registers are all 0. Reset mid-operation aborts the division; no stale result is ever presented.
- All state updates require ce=1. With ce=0, every register holds and the outputs stay stable.
- States:
  - IDLE: in_ready=1. On in_valid & ce: latch |din0| and |din1| as W-bit unsigned magnitudes (|-2^(W-1)| = 2^(W-1) held unsigned), latch the sign bits, latch the special-case flags, clear the partial remainder, set count=0, go to CALC.
  - CALC: one restoring step per ce cycle. Shift {rem, dividend} left by 1; trial = rem - divisor; if trial ≥ 0, then rem = trial and shift in quotient bit 1, else shift in 0. Increment count. After step W (count = W-1 at the edge), go to FIX.
  - FIX: apply signs. The quotient is negated if the signs differ; the remainder is negated if the dividend is negative. Apply special cases, register the outputs, set out_valid=1, go to DONE.
  - DONE: outputs held stable while out_valid=1. On out_ready & ce: out_valid=0, go to IDLE.
- in_ready = (state==IDLE). This is a registered-state decode and is never combinationally dependent on in_valid. There is no acceptance in DONE: at most one operation is in flight.
- Latency: acceptance edge E0. out_valid rises at edge E0+W+1 (17 cycles for W=16), counting ce=1 edges only. Latency is constant, special cases included.
- Throughput: a new operand is accepted no earlier than the edge after the result handshake.
- Divide by zero (din1=0): quot = 2^(W-1)-1 if din0 ≥ 0, else -2^(W-1). rem = din0. div_by_zero=1.
- Overflow (din0=-2^(W-1), din1=-1): quot = -2^(W-1) (wrap), rem = 0, overflow=1.
- Flags are valid only when out_valid=1 and are cleared on the next acceptance.
- Arithmetic: the trial subtraction uses W+1 bits to avoid sign loss. Magnitudes are W-bit unsigned, and the final negation is truncated to W bits.
- Simultaneous out_ready and in_valid in DONE: only the result handshake completes; the input is accepted in the following IDLE cycle.

Decomposition:
- Package spmm_hls_div_pkg contains:
  - state enum {IDLE, CALC, FIX, DONE}
  - constants DIV_W=16 and DIV_CNT_W=5
  - a function returning MIN_INT/MAX_INT for a given width
- One natural sub-module, spmm_hls_div_step: combinational single restoring iteration, with inputs {rem, dividend_msb, divisor} and outputs {next_rem, q_bit}. It is instantiated once in the top FSM.

Test Plan:
- 100 / 7 → out_valid 17 cycles after accept; quot=14, rem=2, both flags 0.
- -100 / 7 → quot=-14 (0xFFF2), rem=-2 (0xFFFE); 100 / -7 → quot=-14, rem=2.
- 7 / 0 → quot=0x7FFF, rem=7, div_by_zero=1; -5 / 0 → quot=0x8000, rem=-5, div_by_zero=1.
- -32768 / -1 → quot=0x8000, rem=0, overflow=1; -32768 / 1 → quot=0x8000, rem=0, flags 0.
- Backpressure and ce:
  - Hold out_ready=0 for 10 cycles: quot/rem are stable and in_ready=0.
  - Toggle ce low for 5 cycles mid-CALC: latency stretches by exactly 5 cycles and the result is unchanged.
- Assert reset=0 at step 8 of 1000/3: all outputs go to 0 immediately and in_ready=1 after release. A new 9/4 then returns quot=2, rem=1.

Source files
------------

// File: rtl/spmm_hls_div_pkg.sv
// Shared types and constants for the SpMM sequential signed divider.
// Both the FSM top and the restoring-step datapath import this package.
package spmm_hls_div_pkg;

  localparam int DIV_W     = 16;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement MIN_INT (want_min=1) or MAX_INT bit pattern for width w (w <= 32)
  function automatic logic [31:0] int_limit(input int w, input logic want_min);
    logic [31:0] min_pat;
    min_pat = 32'd1 << (w - 1);
    return want_min ? min_pat : (min_pat - 32'd1);
  endfunction

endpackage

// File: rtl/spmm_hls_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// The trial subtraction is one bit wider than the operands so its sign is never lost.
module spmm_hls_div_step
  import spmm_hls_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] rem,
  input  logic         dividend_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_rem,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  always_comb begin
    shifted  = {rem, dividend_msb};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[W];
    next_rem = q_bit ? trial[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/spmm_hls_sdiv_16s_16s_16_seq.sv
// Sequential signed divider (C truncation semantics) with valid/ready handshakes.
// Constant latency of W+1 enabled cycles from acceptance to out_valid.
module spmm_hls_sdiv_16s_16s_16_seq
  import spmm_hls_div_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam logic [W-1:0] MIN_INT = W'(int_limit(W, 1'b1));
  localparam logic [W-1:0] MAX_INT = W'(int_limit(W, 1'b0));

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0] part_q, part_d;
  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic sign_n_q, sign_n_d;
  logic sign_d_q, sign_d_d;
  logic dbz_q, dbz_d;
  logic ovf_q, ovf_d;
  logic [W-1:0] quot_q, quot_d;
  logic [W-1:0] res_rem_q, res_rem_d;
  logic div_by_zero_q, div_by_zero_d;
  logic overflow_q, overflow_d;
  logic out_valid_q, out_valid_d;

  logic [W-1:0] step_rem;
  logic         step_q_bit;
  logic [W-1:0] din0_mag, din1_mag;
  logic [W-1:0] quot_norm, rem_norm;

  spmm_hls_div_step #(.W(W)) u_step (
    .rem          (part_q),
    .dividend_msb (dvd_q[W-1]),
    .divisor      (dvs_q),
    .next_rem     (step_rem),
    .q_bit        (step_q_bit)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    part_d        = part_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    sign_n_d      = sign_n_q;
    sign_d_d      = sign_d_q;
    dbz_d         = dbz_q;
    ovf_d         = ovf_q;
    quot_d        = quot_q;
    res_rem_d     = res_rem_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    out_valid_d   = out_valid_q;

    din0_mag  = din0[W-1] ? (~din0 + W'(1)) : din0;
    din1_mag  = din1[W-1] ? (~din1 + W'(1)) : din1;
    quot_norm = (sign_n_q ^ sign_d_q) ? (~dvd_q + W'(1)) : dvd_q;
    rem_norm  = sign_n_q ? (~part_q + W'(1)) : part_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d       = CALC;
          count_d       = '0;
          part_d        = '0;
          dvd_d         = din0_mag;
          dvs_d         = din1_mag;
          sign_n_d      = din0[W-1];
          sign_d_d      = din1[W-1];
          dbz_d         = (din1 == '0);
          ovf_d         = (din0 == MIN_INT) && (din1 == '1);
          div_by_zero_d = 1'b0;
          overflow_d    = 1'b0;
        end
      end
      CALC: begin
        part_d  = step_rem;
        dvd_d   = {dvd_q[W-2:0], step_q_bit};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(W - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // With a zero divisor every step keeps the shifted value, so part_q ends up
        // holding |din0| and rem_norm reconstructs the original dividend.
        if (dbz_q) begin
          quot_d        = sign_n_q ? MIN_INT : MAX_INT;
          res_rem_d     = rem_norm;
          div_by_zero_d = 1'b1;
        end else if (ovf_q) begin
          quot_d     = MIN_INT;
          res_rem_d  = '0;
          overflow_d = 1'b1;
        end else begin
          quot_d    = quot_norm;
          res_rem_d = rem_norm;
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      part_q        <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      sign_n_q      <= 1'b0;
      sign_d_q      <= 1'b0;
      dbz_q         <= 1'b0;
      ovf_q         <= 1'b0;
      quot_q        <= '0;
      res_rem_q     <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      out_valid_q   <= 1'b0;
    end else if (ce) begin
      state_q       <= state_d;
      count_q       <= count_d;
      part_q        <= part_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      sign_n_q      <= sign_n_d;
      sign_d_q      <= sign_d_d;
      dbz_q         <= dbz_d;
      ovf_q         <= ovf_d;
      quot_q        <= quot_d;
      res_rem_q     <= res_rem_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quot        = quot_q;
  assign rem         = res_rem_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_spmm_hls_sdiv_16s_16s_16_seq.sv
// Self-checking bench for the sequential signed divider: directed corner cases,
// backpressure, clock-enable stalls, mid-operation reset and randomized operands.
module tb_spmm_hls_sdiv_16s_16s_16_seq;

  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ce = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  din0 = '0;
  logic [W-1:0]  din1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  quot;
  logic [W-1:0]  rem;
  logic          div_by_zero;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  spmm_hls_sdiv_16s_16s_16_seq #(.W(W), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // C-style signed division on plain integers, with the two special cases
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output logic o);
    int ai;
    int bi;
    ai = int'(signed'(a));
    bi = int'(signed'(b));
    z = 1'b0;
    o = 1'b0;
    if (bi == 0) begin
      q = (ai < 0) ? 16'h8000 : 16'h7FFF;
      r = a;
      z = 1'b1;
    end else if (ai == -32768 && bi == -1) begin
      q = 16'h8000;
      r = 16'h0000;
      o = 1'b1;
    end else begin
      q = 16'(ai / bi);
      r = 16'(ai % bi);
    end
  endfunction

  task automatic waitResult(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int ce_gap_at, input int ce_gap_len,
                               input int hold, input bit overlap);
    logic [W-1:0] exp_q, exp_r;
    logic exp_z, exp_o;
    int edges;
    bit stable;
    model(a, b, exp_q, exp_r, exp_z, exp_o);

    edges = 0;
    while (!in_ready && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("in_ready_busy", 32'(in_ready), 32'd0);

    edges = 0;
    while (!out_valid && edges < 200) begin
      if (ce_gap_len > 0 && edges == ce_gap_at) ce = 1'b0;
      if (ce_gap_len > 0 && edges == ce_gap_at + ce_gap_len) ce = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    ce = 1'b1;
    checkOutput("latency", 32'(edges), 32'(LAT + ce_gap_len));
    checkOutput("quot", 32'(quot), 32'(exp_q));
    checkOutput("rem", 32'(rem), 32'(exp_r));
    checkOutput("div_by_zero", 32'(div_by_zero), 32'(exp_z));
    checkOutput("overflow", 32'(overflow), 32'(exp_o));

    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (quot !== exp_q || rem !== exp_r || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) checkOutput("hold_stable", 32'(stable), 32'd1);

    out_ready = 1'b1;
    if (overlap) begin
      din0 = 16'd5;
      din1 = 16'd2;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid_cleared", 32'(out_valid), 32'd0);
    checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);

    if (overlap) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("overlap_accepted_next", 32'(in_ready), 32'd0);
      waitResult(edges);
      checkOutput("overlap_latency", 32'(edges), 32'(LAT));
      checkOutput("overlap_quot", 32'(quot), 32'd2);
      checkOutput("overlap_rem", 32'(rem), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("overlap_drained", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;

    reset = 1'b0;
    ce = 1'b1;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quot", 32'(quot), 32'd0);
    checkOutput("reset_rem", 32'(rem), 32'd0);
    checkOutput("reset_flags", 32'({div_by_zero, overflow}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(16'd100, 16'd7, 0, 0, 0, 1'b0);
    applyStimulus(16'(-100), 16'd7, 0, 0, 0, 1'b0);
    applyStimulus(16'd100, 16'(-7), 0, 0, 0, 1'b0);
    applyStimulus(16'd7, 16'd0, 0, 0, 0, 1'b0);
    applyStimulus(16'(-5), 16'd0, 0, 0, 0, 1'b0);
    applyStimulus(16'h8000, 16'hFFFF, 0, 0, 0, 1'b0);
    applyStimulus(16'h8000, 16'd1, 0, 0, 0, 1'b0);
    applyStimulus(16'd1234, 16'(-56), 0, 0, 10, 1'b0);
    applyStimulus(16'(-3000), 16'd17, 5, 5, 0, 1'b0);
    applyStimulus(16'd77, 16'd8, 0, 0, 0, 1'b1);

    $display("[TB] mid-operation reset on 1000/3");
    din0 = 16'd1000;
    din1 = 16'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_quot", 32'(quot), 32'd0);
    checkOutput("abort_rem", 32'(rem), 32'd0);
    checkOutput("abort_flags", 32'({div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_no_stale", 32'(out_valid), 32'd0);
    applyStimulus(16'd9, 16'd4, 0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rb = 16'd0;
      else if (sel == 1) rb = 16'hFFFF;
      else if (sel < 5)  rb = $urandom_range(0, 1) ? 16'($urandom_range(1, 15)) : 16'(-int'($urandom_range(1, 15)));
      else               rb = 16'($urandom);
      ra = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      applyStimulus(ra, rb, 0, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
